// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared types and helpers for the Morse key-line serializer.
//   PATTERN_W : width of a right-aligned Morse pattern from the encoder
//   IDX_W     : width of a bit index / bit count inside a pattern
//   state_e   : serializer FSM states
//   msb_index : priority encoder, index of the highest set bit (0 for zero)
// -----------------------------------------------------------------------------
package morse_pkg;

  localparam int PATTERN_W = 24;
  localparam int IDX_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Ascending scan so the last hit wins, i.e. the highest set bit.
  function automatic logic [IDX_W-1:0] msb_index(input logic [PATTERN_W-1:0] p);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < PATTERN_W; i++) begin
      if (p[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/morse_unit_tick.sv
// -----------------------------------------------------------------------------
// morse_unit_tick
// Divides the system clock into Morse units. The counter walks
// 0..TICK_DIV-1 while run is high; unit_tick marks the last cycle of a unit.
// Ports:
//   clk       in  system clock
//   rst       in  asynchronous active-high reset
//   clear     in  restart the unit at count 0 (character accepted)
//   run       in  count enable (serializer busy)
//   unit_tick out high on the final cycle of each unit while running
// -----------------------------------------------------------------------------
module morse_unit_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic unit_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: next-state defaults to the current value first, so every path assigns
  // cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together on the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // With TICK_DIV=1 the counter stays at 0 and this is simply run.
  assign unit_tick = run && (cnt_q == LAST);

endmodule

// File: rtl/morse_serializer.sv
// -----------------------------------------------------------------------------
// morse_serializer
// Plays one right-aligned Morse pattern per character on a single key line,
// MSB-first from the highest set bit, one pattern bit per unit, then appends
// an inter-character gap. A zero pattern (space) yields a word gap.
// Ports:
//   clk       in  system clock
//   rst       in  asynchronous active-high reset (drops any character in flight)
//   pattern   in  24-bit Morse pattern, leading zeros ignored
//   in_valid  in  pattern valid
//   in_ready  out high only in IDLE; accept = in_valid & in_ready
//   key       out registered key line, 1 = tone on
//   busy      out character in progress (SEND or GAP)
//   done      out one-cycle pulse on the first IDLE cycle after a character
// -----------------------------------------------------------------------------
module morse_serializer
  import morse_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int GAP_UNITS  = 3,
  parameter int WORD_UNITS = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 key,
  output logic                 busy,
  output logic                 done
);

  localparam int UNIT_MAX = (GAP_UNITS > WORD_UNITS) ? GAP_UNITS : WORD_UNITS;
  localparam int UNIT_W   = $clog2(UNIT_MAX + 1);

  state_e               state_q, state_d;
  // Pattern is left-aligned on accept so the bit being played is always the top bit.
  logic [PATTERN_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [UNIT_W-1:0]    unit_cnt_q, unit_cnt_d;
  logic                 key_q, key_d;
  logic                 done_q, done_d;

  logic                 is_idle;
  logic                 accept;
  logic                 unit_tick;
  logic [IDX_W-1:0]     msb;

  // Any encoding other than SEND/GAP is treated as IDLE.
  assign is_idle = !((state_q == SEND) || (state_q == GAP));
  assign accept  = is_idle && in_valid;
  assign msb     = msb_index(pattern);

  morse_unit_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_unit_tick (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .run       (!is_idle),
    .unit_tick (unit_tick)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    unit_cnt_d = unit_cnt_q;
    done_d     = 1'b0;

    case (state_q)
      SEND: begin
        if (unit_tick) begin
          if (bit_cnt_q == IDX_W'(1)) begin
            state_d    = GAP;
            unit_cnt_d = UNIT_W'(GAP_UNITS);
            bit_cnt_d  = '0;
          end else begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end

      GAP: begin
        if (unit_tick) begin
          if (unit_cnt_q == UNIT_W'(1)) begin
            state_d    = IDLE;
            unit_cnt_d = '0;
            done_d     = 1'b1;
          end else begin
            unit_cnt_d = unit_cnt_q - 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        if (in_valid) begin
          shreg_d   = pattern << (IDX_W'(PATTERN_W - 1) - msb);
          bit_cnt_d = msb + 1'b1;
          if (pattern == '0) begin
            state_d    = GAP;
            unit_cnt_d = UNIT_W'(WORD_UNITS);
            bit_cnt_d  = '0;
          end else begin
            state_d = SEND;
          end
        end
      end
    endcase

    // Key follows the bit that will be current next cycle, so it is glitch-free.
    key_d = (state_d == SEND) && shreg_d[PATTERN_W-1];
  end

  // NOTE: the shift register is reset along with the counters; it is ordinary
  // control-path state, not a memory, and a clean value keeps key defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      unit_cnt_q <= '0;
      key_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      unit_cnt_q <= unit_cnt_d;
      key_q      <= key_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = is_idle;
  assign busy     = !is_idle;
  assign key      = key_q;
  assign done     = done_q;

endmodule

// File: tb/tb_morse_serializer.sv
// -----------------------------------------------------------------------------
// tb_morse_serializer
// Two instances share clock and reset: dut (TICK_DIV=2) and dut1 (TICK_DIV=1).
// The reference model expands each pattern into a list of key units from the
// Morse rules and compares every cycle between accept and done.
// -----------------------------------------------------------------------------
module tb_morse_serializer;

  localparam int TD = 2;
  localparam int GU = 3;
  localparam int WU = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pattern  = '0;
  logic [23:0] pattern1 = '0;
  logic        in_valid  = 1'b0;
  logic        in_valid1 = 1'b0;
  logic        in_ready, key, busy, done;
  logic        in_ready1, key1, busy1, done1;

  int checks = 0;
  int errors = 0;

  bit exp_units[$];

  always #5 clk = ~clk;

  morse_serializer #(.TICK_DIV(TD), .GAP_UNITS(GU), .WORD_UNITS(WU)) dut (
    .clk      (clk),
    .rst      (rst),
    .pattern  (pattern),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .key      (key),
    .busy     (busy),
    .done     (done)
  );

  morse_serializer #(.TICK_DIV(1), .GAP_UNITS(GU), .WORD_UNITS(WU)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .pattern  (pattern1),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .key      (key1),
    .busy     (busy1),
    .done     (done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Morse rules: bits from the highest set bit down to bit 0, then the gap;
  // a zero pattern is a word gap only.
  function automatic void build_units(input logic [23:0] p);
    int top;
    exp_units.delete();
    if (p == 24'd0) begin
      repeat (WU) exp_units.push_back(1'b0);
    end else begin
      top = 23;
      while (!p[top]) top--;
      for (int i = top; i >= 0; i--) exp_units.push_back(p[i]);
      repeat (GU) exp_units.push_back(1'b0);
    end
  endfunction

  // k counts cycles after the accept edge; done is due at k = units*td.
  task automatic check_at(input string name, input logic [23:0] p, input int k, input int td,
                          input logic k_o, input logic b_o, input logic d_o, input logic r_o);
    int n;
    string t;
    n = exp_units.size();
    t = $sformatf("%s p=%06h k=%0d", name, p, k);
    if (k < n * td) begin
      check({t, " key"},      32'(k_o), 32'(exp_units[k / td]));
      check({t, " busy"},     32'(b_o), 32'd1);
      check({t, " done"},     32'(d_o), 32'd0);
      check({t, " in_ready"}, 32'(r_o), 32'd0);
    end else begin
      check({t, " end key"},      32'(k_o), 32'd0);
      check({t, " end busy"},     32'(b_o), 32'd0);
      check({t, " end done"},     32'(d_o), 32'd1);
      check({t, " end in_ready"}, 32'(r_o), 32'd1);
    end
  endtask

  // Called at a negedge with dut idle (or in its done cycle). hold keeps
  // in_valid high so next_p is accepted on the done cycle; scramble changes
  // the pattern input every cycle while the character is in flight.
  task automatic play(input logic [23:0] p, input bit use1, input bit scramble,
                      input bit hold, input logic [23:0] next_p);
    int n;
    build_units(p);
    n = exp_units.size();
    pattern  = p;
    in_valid = 1'b1;
    if (use1) begin
      pattern1  = p;
      in_valid1 = 1'b1;
    end
    @(negedge clk);
    in_valid1 = 1'b0;
    if (!hold) in_valid = 1'b0;
    for (int k = 0; k <= n * TD; k++) begin
      check_at("td2", p, k, TD, key, busy, done, in_ready);
      if (use1 && k <= n) check_at("td1", p, k, 1, key1, busy1, done1, in_ready1);
      if (k < n * TD) begin
        if (k == n * TD - 1)  pattern = hold ? next_p : p;
        else if (scramble)    pattern = 24'($urandom);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [23:0] p, p_next;
    bit          hold;
    int          m;

    // Reset values, asynchronously applied.
    #1;
    check("rst key",      32'(key),      32'd0);
    check("rst busy",     32'(busy),     32'd0);
    check("rst done",     32'(done),     32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle key",      32'(key),       32'd0);
    check("idle busy",     32'(busy),      32'd0);
    check("idle done",     32'(done),      32'd0);
    check("idle in_ready", 32'(in_ready),  32'd1);
    check("idle1 ready",   32'(in_ready1), 32'd1);

    // Directed characters.
    play(24'b010,        1'b1, 1'b0, 1'b0, 24'd0);  // E
    play(24'b0101110,    1'b1, 1'b0, 1'b0, 24'd0);  // A
    play(24'b0101110101, 1'b1, 1'b0, 1'b0, 24'd0);  // L
    play(24'd0,          1'b1, 1'b0, 1'b0, 24'd0);  // space
    play(24'h800000,     1'b1, 1'b0, 1'b0, 24'd0);  // full width

    // Back-to-back with in_valid held and pattern churning while busy.
    play(24'b010,   1'b0, 1'b1, 1'b1, 24'b01110);   // E then T
    play(24'b01110, 1'b0, 1'b1, 1'b0, 24'd0);

    // Reset in the middle of SEND.
    @(negedge clk);
    pattern   = 24'b0101110;
    pattern1  = 24'b0101110;
    in_valid  = 1'b1;
    in_valid1 = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    in_valid1 = 1'b0;
    check("mid key before rst",   32'(key),   32'd1);
    check("mid busy1 before rst", 32'(busy1), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid rst key",       32'(key),       32'd0);
    check("mid rst busy",      32'(busy),      32'd0);
    check("mid rst in_ready",  32'(in_ready),  32'd1);
    check("mid rst done",      32'(done),      32'd0);
    check("mid rst busy1",     32'(busy1),     32'd0);
    check("mid rst in_ready1", 32'(in_ready1), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post rst done",  32'(done),  32'd0);
      check("post rst busy",  32'(busy),  32'd0);
      check("post rst done1", 32'(done1), 32'd0);
    end

    // Randomized characters, sometimes chained back-to-back.
    p_next = 24'd1;
    for (int it = 0; it < 30; it++) begin
      p = p_next;
      if ($urandom_range(0, 5) == 0) begin
        p_next = 24'd0;
      end else begin
        m      = $urandom_range(0, 23);
        p_next = (24'd1 << m) | (24'($urandom) & ((24'd1 << m) - 24'd1));
      end
      hold = (it != 29) && ($urandom_range(0, 1) == 1);
      play(p, 1'b1, 1'b1, hold, p_next);
    end

    @(negedge clk);
    check("final idle busy",  32'(busy),  32'd0);
    check("final idle busy1", 32'(busy1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_serializer.md
Name: morse_serializer

Overview:
- Downstream stage of the ASCII-to-Morse pattern encoder. Accepts one 24-bit right-aligned Morse pattern per character and plays it out on a single key line, one pattern bit per Morse unit.
- A pattern is 1 = key on for one unit, 0 = key off for one unit, played MSB-first from the highest set bit down to bit 0.
- After the pattern, the block appends an inter-character gap. An all-zero pattern (space) produces a word gap.
- Its output drives the tone/LED/line driver.

Parameters:
- TICK_DIV, 4, clock cycles per Morse unit (>=1)
- GAP_UNITS, 3, key-off units appended after every non-zero pattern
- WORD_UNITS, 7, key-off units emitted for an all-zero pattern

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- pattern  input  24  Morse pattern from encoder, right-aligned, leading zeros ignored
- in_valid  input  1  pattern valid
- in_ready  output  1  block can accept a pattern
- key  output  1  Morse key line, 1 = tone on
- busy  output  1  character in progress (SEND or GAP)
- done  output  1  one-cycle pulse when a character, including its gap, completes

Behaviour:
- Reset: state=IDLE, key=0, busy=0, done=0, in_ready=1, all counters 0. Reset is asynchronous and active-high; it is legal mid-character, and the block returns to IDLE at once and discards the pattern.
- Handshake: a pattern is accepted on a rising edge with in_valid & in_ready. in_ready = (state==IDLE), registered, so it reads 1 only in IDLE. in_valid while busy is ignored, with no queuing.
- Accept in IDLE:
  - A priority encoder finds msb = index of the highest set bit.
  - The pattern is latched into a 24-bit shift register.
  - bit_cnt = msb+1 (5 bits, range 1..24).
  - The tick counter is cleared.
  - Next state is SEND. If pattern==0, next state is GAP with unit_cnt=WORD_UNITS.
- Unit timing:
  - Tick counter counts 0..TICK_DIV-1; unit_tick asserts when count==TICK_DIV-1.
  - The counter runs only in SEND/GAP and is cleared on accept.
  - With TICK_DIV=1, unit_tick is high every active cycle.
- SEND:
  - key (registered) = pattern[msb] from the cycle after accept.
  - Each unit_tick shifts to the next lower bit and decrements bit_cnt.
  - Each bit is held exactly TICK_DIV cycles.
  - On unit_tick with bit_cnt==1: go to GAP with unit_cnt=GAP_UNITS, key=0.
- GAP: key=0. Each unit_tick decrements unit_cnt. On unit_tick with unit_cnt==1: go to IDLE and pulse done for exactly 1 cycle (the first IDLE cycle, coincident with in_ready=1).
- busy=1 in SEND and GAP.
- Character duration, accept edge to done: (msb+1+GAP_UNITS)*TICK_DIV cycles, or WORD_UNITS*TICK_DIV for a zero pattern.
- Back-to-back: if in_valid is held, the next pattern is accepted on the first IDLE edge, i.e. the done cycle. This gives exactly one idle cycle between characters.
- The trailing key-off gap is added regardless of whether pattern bit 0 is 0 or 1.
- 24-bit full pattern (bit 23 set) plays all 24 bits; no overflow.
- Counter widths:
  - unit_cnt: clog2(max(GAP_UNITS,WORD_UNITS)+1) bits.
  - Tick counter: clog2(TICK_DIV) bits, minimum 1.
- An unknown state decodes to IDLE.

Decomposition:
- morse_pkg holds:
  - PATTERN_W=24.
  - State enum {IDLE, SEND, GAP}.
  - An msb priority-encode function returning a 5-bit index.
- Sub-module morse_unit_tick (parameter TICK_DIV):
  - Inputs: clk, rst, clear, run.
  - Output: unit_tick.
- The FSM, shift register and counters stay in morse_serializer.

Test Plan (TICK_DIV=2, GAP_UNITS=3, WORD_UNITS=7):
- Reset released, no stimulus -> key=0, busy=0, done=0, in_ready=1. Assert rst mid-SEND -> key=0, busy=0, in_ready=1 immediately, no done pulse.
- pattern=24'b010 ('E') -> key 1 for 2 cycles, 0 for 2 cycles, then 0 for 6 gap cycles. done at accept+10; busy high 10 cycles.
- pattern=24'b0101110 ('A') -> key sequence 1,0,1,1,1,0, each held 2 cycles, then 6 off cycles. done at accept+18.
- pattern=24'b0101110101 ('L', ends in 1) -> 9 bits 101110101 then 3 gap units. done at accept+24.
- pattern=0 (space) -> key=0 for 14 cycles, done at accept+14. pattern=24'h800000 -> key 1 for 2 cycles, then 0 for the remaining 23 units plus gap 3. done at accept+54.
- in_valid held high with 'E' then 'T' (24'b01110), toggling pattern while busy -> in-flight pattern unchanged; second accept on the done cycle. Then TICK_DIV=1 rerun of 'E' -> done at accept+5.
